axi_lite_master: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 29 ++
 rtl/axi_lite_master.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared AXI-Lite definitions: response codes, write-strobe
//               constant and the state encoding of the AXI-Lite initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    // AXI response codes (BRESP / RRESP)
    localparam logic [1:0] AXI_OK     = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    // Full-word writes only
    localparam logic [3:0] WSTRB_ALL  = 4'hF;

    // Initiator state encoding
    localparam int unsigned STATE_W   = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_WR_REQ  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WR_RESP = 3'd2;
    localparam logic [STATE_W-1:0] ST_RD_REQ  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RD_DATA = 3'd4;
    localparam logic [STATE_W-1:0] ST_RSP     = 3'd5;

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master
// Description : Single-outstanding AXI-Lite initiator. Converts a simple
//               command (write/read, address, data) into one AXI-Lite
//               transaction and returns the slave's response.
//               Ports:
//                 m_axi_lite_aclk / axi_resetn : clock, async active-low reset
//                 cmd_*   : command input  (valid/ready handshake)
//                 rsp_*   : response output (valid/ready handshake)
//                 m_axi_lite_* : AXI-Lite master port (AW, W, B, AR, R)
//               Every output is driven straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_LITE_ADDR_WIDTH = 8
) (
    input  logic                           m_axi_lite_aclk,
    input  logic                           axi_resetn,
    // command channel
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                    cmd_wdata,
    // response channel
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_write,
    output logic [31:0]                    rsp_rdata,
    output logic [1:0]                     rsp_resp,
    // AXI-Lite write address
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
    output logic                           m_axi_lite_awvalid,
    input  logic                           m_axi_lite_awready,
    // AXI-Lite write data
    output logic [31:0]                    m_axi_lite_wdata,
    output logic [3:0]                     m_axi_lite_wstrb,
    output logic                           m_axi_lite_wvalid,
    input  logic                           m_axi_lite_wready,
    // AXI-Lite write response
    input  logic [1:0]                     m_axi_lite_bresp,
    input  logic                           m_axi_lite_bvalid,
    output logic                           m_axi_lite_bready,
    // AXI-Lite read address
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr,
    output logic                           m_axi_lite_arvalid,
    input  logic                           m_axi_lite_arready,
    // AXI-Lite read data
    input  logic [31:0]                    m_axi_lite_rdata,
    input  logic [1:0]                     m_axi_lite_rresp,
    input  logic                           m_axi_lite_rvalid,
    output logic                           m_axi_lite_rready
);

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    logic [STATE_W-1:0]             r_state;
    logic                           r_cmd_ready;
    logic                           r_rsp_valid;
    logic                           r_rsp_write;
    logic [31:0]                    r_rsp_rdata;
    logic [1:0]                     r_rsp_resp;
    logic [AXI_LITE_ADDR_WIDTH-1:0] r_awaddr;
    logic                           r_awvalid;
    logic [31:0]                    r_wdata;
    logic                           r_wvalid;
    logic                           r_bready;
    logic [AXI_LITE_ADDR_WIDTH-1:0] r_araddr;
    logic                           r_arvalid;
    logic                           r_rready;
    logic                           r_aw_done;
    logic                           r_w_done;

    // ------------------------------------------------------------------------
    // Handshake decode. The "done" wires fold in a handshake happening this
    // cycle so WR_RESP is entered in the cycle right after the later of the
    // two request handshakes, not one cycle later.
    // ------------------------------------------------------------------------
    logic w_cmd_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;

    assign w_cmd_hs  = cmd_valid & r_cmd_ready;
    assign w_aw_hs   = r_awvalid & m_axi_lite_awready;
    assign w_w_hs    = r_wvalid  & m_axi_lite_wready;
    assign w_aw_done = r_aw_done | w_aw_hs;
    assign w_w_done  = r_w_done  | w_w_hs;

    // ------------------------------------------------------------------------
    // FSM with holding registers
    // ------------------------------------------------------------------------
    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= AXI_OK;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // cmd_ready comes up one cycle after reset release and
                    // after every response handshake.
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_hs) begin
                        r_cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_REQ;
                        end
                    end
                end

                ST_WR_REQ: begin
                    // AW and W complete independently, in any order
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= ST_WR_RESP;
                    end else begin
                        r_aw_done <= w_aw_done;
                        r_w_done  <= w_w_done;
                    end
                end

                ST_WR_RESP: begin
                    // bready is high throughout this state
                    if (m_axi_lite_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axi_lite_bresp;
                        r_rsp_rdata <= '0;
                        r_rsp_write <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end

                ST_RD_REQ: begin
                    if (m_axi_lite_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end

                ST_RD_DATA: begin
                    // rready is high throughout this state
                    if (m_axi_lite_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= m_axi_lite_rdata;
                        r_rsp_resp  <= m_axi_lite_rresp;
                        r_rsp_write <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: drop every handshake and restart
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_bready    <= 1'b0;
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                    r_aw_done   <= 1'b0;
                    r_w_done    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign cmd_ready          = r_cmd_ready;
    assign rsp_valid          = r_rsp_valid;
    assign rsp_write          = r_rsp_write;
    assign rsp_rdata          = r_rsp_rdata;
    assign rsp_resp           = r_rsp_resp;
    assign m_axi_lite_awaddr  = r_awaddr;
    assign m_axi_lite_awvalid = r_awvalid;
    assign m_axi_lite_wdata   = r_wdata;
    assign m_axi_lite_wstrb   = WSTRB_ALL;
    assign m_axi_lite_wvalid  = r_wvalid;
    assign m_axi_lite_bready  = r_bready;
    assign m_axi_lite_araddr  = r_araddr;
    assign m_axi_lite_arvalid = r_arvalid;
    assign m_axi_lite_rready  = r_rready;

endmodule : axi_lite_master
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_master
// Description : Self-checking bench for axi_lite_master with a configurable
//               AXI-Lite slave model (16-word register file, per-channel
//               ready/valid delays, programmable response code).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

    logic        clk;
    logic        axi_resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    axi_lite_master #(.AXI_LITE_ADDR_WIDTH(8)) u_dut (
        .m_axi_lite_aclk    (clk),
        .axi_resetn         (axi_resetn),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_write          (rsp_write),
        .rsp_rdata          (rsp_rdata),
        .rsp_resp           (rsp_resp),
        .m_axi_lite_awaddr  (awaddr),
        .m_axi_lite_awvalid (awvalid),
        .m_axi_lite_awready (awready),
        .m_axi_lite_wdata   (wdata),
        .m_axi_lite_wstrb   (wstrb),
        .m_axi_lite_wvalid  (wvalid),
        .m_axi_lite_wready  (wready),
        .m_axi_lite_bresp   (bresp),
        .m_axi_lite_bvalid  (bvalid),
        .m_axi_lite_bready  (bready),
        .m_axi_lite_araddr  (araddr),
        .m_axi_lite_arvalid (arvalid),
        .m_axi_lite_arready (arready),
        .m_axi_lite_rdata   (rdata),
        .m_axi_lite_rresp   (rresp),
        .m_axi_lite_rvalid  (rvalid),
        .m_axi_lite_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Slave model
    // ------------------------------------------------------------------------
    int          cfg_aw = 0, cfg_w = 0, cfg_b = 1, cfg_ar = 0, cfg_r = 1;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] mem [16];
    logic        aw_got, w_got, b_pend, r_pend;
    logic [7:0]  aw_q;
    logic [31:0] w_q, rd_q;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_hs, w_hs, ar_hs;

    assign awready = !aw_got && (aw_cnt >= cfg_aw);
    assign wready  = !w_got  && (w_cnt  >= cfg_w);
    assign arready = !r_pend && !rvalid && (ar_cnt >= cfg_ar);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid  && wready;
    assign ar_hs   = arvalid && arready;
    assign bresp   = cfg_resp;
    assign rresp   = cfg_resp;
    assign rdata   = rd_q;

    always @(posedge clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_q <= '0; w_q <= '0; rd_q <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= (i == 7) ? 32'hDEAD_BEEF : 32'h0;
        end else begin
            if (aw_hs) aw_cnt <= 0; else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs)  w_cnt  <= 0; else if (wvalid)  w_cnt  <= w_cnt + 1;
            if (ar_hs) ar_cnt <= 0; else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (aw_hs) begin aw_got <= 1'b1; aw_q <= awaddr; end
            if (w_hs)  begin w_got  <= 1'b1; w_q  <= wdata;  end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                mem[aw_got ? aw_q[5:2] : awaddr[5:2]] <= w_got ? w_q : wdata;
                if (cfg_b == 0) bvalid <= 1'b1;
                else begin b_pend <= 1'b1; b_cnt <= cfg_b - 1; end
            end
            if (b_pend) begin
                if (b_cnt == 0) begin bvalid <= 1'b1; b_pend <= 1'b0; end
                else b_cnt <= b_cnt - 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (ar_hs) begin
                rd_q <= mem[araddr[5:2]];
                if (cfg_r == 0) rvalid <= 1'b1;
                else begin r_pend <= 1'b1; r_cnt <= cfg_r - 1; end
            end
            if (r_pend) begin
                if (r_cnt == 0) begin rvalid <= 1'b1; r_pend <= 1'b0; end
                else r_cnt <= r_cnt - 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Protocol monitor (sampled on the falling edge)
    // ------------------------------------------------------------------------
    logic       p_aw_pend, p_w_pend, p_ar_pend;
    logic [7:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    int n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0;

    always @(negedge clk) begin
        if (!axi_resetn) begin
            p_aw_pend <= 1'b0; p_w_pend <= 1'b0; p_ar_pend <= 1'b0;
        end else begin
            if (p_aw_pend) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_w_pend)  check("w_hold",  {wvalid, wdata},  {1'b1, p_wdata});
            if (p_ar_pend) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            if (bready)    check("b_early", {awvalid, wvalid}, 2'b00);
            if (rready)    check("r_early", arvalid, 1'b0);
            n_aw_hs <= n_aw_hs + int'(awvalid && awready);
            n_w_hs  <= n_w_hs  + int'(wvalid && wready);
            n_b_hs  <= n_b_hs  + int'(bvalid && bready);
            p_aw_pend <= awvalid && !awready; p_awaddr <= awaddr;
            p_w_pend  <= wvalid && !wready;   p_wdata  <= wdata;
            p_ar_pend <= arvalid && !arready; p_araddr <= araddr;
        end
    end

    // ------------------------------------------------------------------------
    // Command helpers
    // ------------------------------------------------------------------------
    logic        tr_aw [32];
    logic        tr_w  [32];
    logic        tr_b  [32];
    logic        tr_hs [32];
    logic [31:0] exp_mem [16];

    task automatic init_exp();
        for (int i = 0; i < 16; i++) exp_mem[i] = (i == 7) ? 32'hDEAD_BEEF : 32'h0;
    endtask

    // Present a command and return at the falling edge of cycle 1
    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
        int k;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        if (!cmd_ready) check("cmd_timeout", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait for rsp_valid, recording bus activity per cycle; lat = cycle index
    task automatic wait_rsp(output int lat);
        int n;
        n = 1;
        while (n < 100) begin
            if (n < 32) begin
                tr_aw[n] = awvalid; tr_w[n] = wvalid; tr_b[n] = bready;
                tr_hs[n] = awvalid && awready && wvalid && wready;
            end
            if (rsp_valid) break;
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_timeout", rsp_valid, 1'b1);
        lat = n;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_once", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int lat, hs0, ws0, bs0;
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;

        axi_resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        init_exp();
        for (int i = 0; i < 32; i++) begin
            tr_aw[i] = 1'b0; tr_w[i] = 1'b0; tr_b[i] = 1'b0; tr_hs[i] = 1'b0;
        end

        // Reset values
        @(negedge clk);
        check("rst_ctrl", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
        check("rst_rsp",  {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
        check("rst_bus",  {awaddr, araddr, wdata}, 48'h0);
        @(negedge clk);
        axi_resetn = 1'b1;
        @(negedge clk);
        check("rst_release_ready", cmd_ready, 1'b1);

        // Write 0x64 to 0x04 against regfile timing
        issue(1'b1, 8'h04, 32'h0000_0064);
        check("wstrb", wstrb, 4'hF);
        wait_rsp(lat);
        check("wr_hs_cycle1", tr_hs[1], 1'b1);
        check("wr_latency", lat, 4);
        check("wr_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
        take_rsp();
        exp_mem[1] = 32'h64;

        // Read it back
        issue(1'b0, 8'h04, 32'hFFFF_FFFF);
        wait_rsp(lat);
        check("rd_latency", lat, 4);
        check("rd_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h0000_0064});
        take_rsp();

        // Zero-wait write slave
        cfg_b = 0;
        issue(1'b1, 8'h08, 32'hA5A5_5A5A);
        wait_rsp(lat);
        check("wr0_latency", lat, 3);
        take_rsp();
        exp_mem[2] = 32'hA5A5_5A5A;
        cfg_b = 1;

        // Staggered ready: awready held low 3 cycles, wready immediate
        cfg_aw = 3;
        hs0 = n_aw_hs; ws0 = n_w_hs; bs0 = n_b_hs;
        issue(1'b1, 8'h0C, 32'h1357_9BDF);
        wait_rsp(lat);
        check("stg_wvalid", {tr_w[1], tr_w[2]}, 2'b10);
        check("stg_awvalid", {tr_aw[2], tr_aw[3], tr_aw[4], tr_aw[5]}, 4'b1110);
        check("stg_bready", {tr_b[1], tr_b[2], tr_b[3], tr_b[4], tr_b[5]}, 5'b00001);
        check("stg_latency", lat, 7);
        take_rsp();
        check("stg_hs_counts", {n_aw_hs - hs0, n_w_hs - ws0, n_b_hs - bs0}, {32'd1, 32'd1, 32'd1});
        exp_mem[3] = 32'h1357_9BDF;
        cfg_aw = 0;

        // Read error pass-through
        cfg_resp = 2'b10;
        issue(1'b0, 8'h1C, 32'h0);
        wait_rsp(lat);
        check("rderr_latency", lat, 4);
        check("rderr_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b10, 32'hDEAD_BEEF});
        take_rsp();
        cfg_resp = 2'b00;

        // Response backpressure with a pending command
        issue(1'b0, 8'h04, 32'h0);
        wait_rsp(lat);
        cmd_write = 1'b1; cmd_addr = 8'h14; cmd_wdata = 32'h0000_1234; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata},
                  {1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0064});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_release", {rsp_valid, cmd_ready}, 2'b01);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_accepted", cmd_ready, 1'b0);
        wait_rsp(lat);
        check("bp_wr_latency", lat, 4);
        take_rsp();
        exp_mem[5] = 32'h0000_1234;

        // Reset in WR_RESP
        cfg_b = 10;
        issue(1'b1, 8'h10, 32'h0000_0055);
        @(negedge clk);
        @(negedge clk);
        check("mid_in_wr_resp", bready, 1'b1);
        #2 axi_resetn = 1'b0;
        #1;
        check("mid_async", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 7'b0);
        @(negedge clk);
        @(negedge clk);
        axi_resetn = 1'b1;
        init_exp();
        cfg_b = 1;
        @(negedge clk);
        check("mid_ready", cmd_ready, 1'b1);
        issue(1'b1, 8'h10, 32'h0000_0077);
        wait_rsp(lat);
        check("mid_wr_latency", lat, 4);
        check("mid_wr_rsp", {rsp_write, rsp_resp}, 3'b100);
        take_rsp();
        exp_mem[4] = 32'h77;
        issue(1'b0, 8'h10, 32'h0);
        wait_rsp(lat);
        check("mid_rd_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h0000_0077});
        take_rsp();

        // Mixed commands with random delays against the expected register file
        for (int t = 0; t < 40; t++) begin
            cfg_aw = $urandom_range(0, 7); cfg_w = $urandom_range(0, 7);
            cfg_b  = $urandom_range(0, 7); cfg_ar = $urandom_range(0, 7);
            cfg_r  = $urandom_range(0, 7);
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15)) << 2;
            d = $urandom;
            issue(w, a, d);
            wait_rsp(lat);
            check("mix_rsp", {rsp_write, rsp_resp, rsp_rdata},
                  {w, 2'b00, (w ? 32'h0 : exp_mem[a[5:2]])});
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take_rsp();
            if (w) exp_mem[a[5:2]] = d;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_axi_lite_master
`default_nettype wire
